dino_jump_ctrl: RTL and testbench
=================================

// Module: dino_jump_ctrl
// PURPOSE
//   Receiving end of the debounced button interface: turns stretched jump/duck button levels into dino motion.
//   Detects press edges, latches a jump request until the next frame tick, then integrates a per-tick
//   velocity/gravity model to produce dino height above ground. Feeds the sprite renderer and collision logic.
// PARAMETERS
//   Y_W        7    width of dino_y (unsigned height, 0 = ground)
//   V_W        6    width of signed vertical velocity
//   JUMP_V     12   launch velocity, units per tick
//   GRAVITY    1    velocity decrement per tick (2*GRAVITY while fast-falling)
//   HOLD_TICKS 6    max rising ticks with gravity suppressed while jump held
//   MAX_Y      100  height ceiling (clamp)
//   MAX_FALL   15   magnitude limit on downward velocity
// PORTS
//   clk          in   1    system clock; only clock in block
//   reset        in   1    synchronous, active-high reset
//   tick_en      in   1    one-cycle frame tick; all motion updates on this
//   freeze       in   1    game-over/pause: hold all state, ignore buttons
//   jump_btn     in   1    debounced jump level
//   duck_btn     in   1    debounced duck level
//   dino_y       out  Y_W  current height above ground
//   airborne     out  1    state != GROUNDED
//   ducking      out  1    duck_btn && state == GROUNDED (registered)
//   jump_start   out  1    one-cycle pulse on launch
//   landed       out  1    one-cycle pulse on touchdown
// BEHAVIOUR
//   Reset: dino_y=0, vel=0, state=GROUNDED, jump_req=0, btn_q=0, all outputs 0. Reset beats every other input.
//   Edge: press = jump_btn & ~btn_q; btn_q updates every cycle, including during freeze.
//   jump_req: set by press while GROUNDED and !freeze. Cleared on launch or on freeze.
//     Held level never relaunches: a new edge is required after landing.
//   States: GROUNDED, RISING, FALLING. No update when !tick_en or freeze.
//   GROUNDED & tick & jump_req: y<=JUMP_V, vel<=JUMP_V-GRAVITY, hold_cnt<=0, ->RISING.
//     jump_start=1 next cycle.
//   RISING tick:
//     - ynext = y+vel. If ynext > MAX_Y: y<=MAX_Y, vel<=0, ->FALLING.
//     - Else y<=ynext. If jump_btn && hold_cnt<HOLD_TICKS: vel unchanged, hold_cnt++.
//       Otherwise vel-=g. If new vel <= 0: ->FALLING.
//   FALLING tick: if y+vel <= 0 (compare in Y_W+1 signed): y<=0, vel<=0, ->GROUNDED, landed=1 next cycle.
//     Else y<=y+vel, vel<=max(vel-g, -MAX_FALL).
//   g = 2*GRAVITY when duck_btn && airborne (fast fall), else GRAVITY.
//   Arithmetic: vel signed V_W; sums sign-extended to Y_W+1 before compare/clamp; dino_y never wraps.
//   Pulses: jump_start/landed high exactly one clk, registered; never both in same cycle.
//   freeze mid-air: position/velocity held; resumes same trajectory when freeze drops.
// STRUCTURE
//   dino_pkg: state enum (GROUNDED/RISING/FALLING), Y_W/V_W defaults, sign-extend helper function.
//   Sub-module button_edge (clk, reset, level_in -> rise_pulse) for jump edge detect; rest is inline FSM + datapath.
// TESTING
//   Tap (jump_btn high 1 cycle, then tick_en) -> jump_start pulse; y=12,23,33,...; peak dino_y=78 on tick 12; ->FALLING.
//   Fall from 78 -> y=77,75,72,...,23,12,0; landed pulse on touchdown tick; airborne=0.
//   Jump held throughout -> y=12,23,...,78 (6 hold ticks), 89, 99; tick 10 clamps y=100, vel=0, FALLING.
//   Hold jump_btn through landing -> no relaunch. Release + press -> launch on next tick.
//   duck_btn at apex y=78 -> vel steps -2,-4,...; landing earlier than plain fall; grounded duck -> ducking=1, y=0.
//   freeze at y=50 for 20 ticks -> y stays 50, press ignored. reset mid-air -> y=0, GROUNDED next cycle, no landed pulse.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared state encoding, default widths and arithmetic helper for the dino jump controller.
package dino_pkg;

    localparam int DINO_Y_W = 7;
    localparam int DINO_V_W = 6;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } dino_state_e;

    // Treats the low w bits of raw as two's complement and widens them to a full int.
    function automatic int sext(input logic [31:0] raw, input int w);
        int sh;
        sh = 32 - w;
        return $signed(raw << sh) >>> sh;
    endfunction

endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Button/tick inputs and dino motion outputs between the input front end and the jump controller.
interface dino_jump_ctrl_if #(
    parameter int Y_W = 7
);
    logic           tick_en;
    logic           freeze;
    logic           jump_btn;
    logic           duck_btn;
    logic [Y_W-1:0] dino_y;
    logic           airborne;
    logic           ducking;
    logic           jump_start;
    logic           landed;

    modport master (
        output tick_en, freeze, jump_btn, duck_btn,
        input  dino_y, airborne, ducking, jump_start, landed
    );

    modport slave (
        input  tick_en, freeze, jump_btn, duck_btn,
        output dino_y, airborne, ducking, jump_start, landed
    );
endinterface

// File: rtl/button_edge.sv
// Rising-edge detector for a debounced button level; the pulse is combinational off the stored level.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic rise_pulse
);
    logic level_q;

    // The stored level tracks the button every cycle, so a press during pause is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_in;
        end
    end

    assign rise_pulse = level_in & ~level_q;
endmodule

// File: rtl/dino_jump_ctrl.sv
// Jump controller: latches a press, then integrates velocity/gravity once per frame tick into dino height.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   GROUNDED | y = 0, vel = 0; waits for a latched press and a tick
//   RISING   | climbing; gravity suppressed while jump held (bounded)
//   FALLING  | descending; velocity saturates at -MAX_FALL, lands at 0
module dino_jump_ctrl
    import dino_pkg::*;
#(
    parameter int Y_W        = DINO_Y_W,
    parameter int V_W        = DINO_V_W,
    parameter int JUMP_V     = 12,
    parameter int GRAVITY    = 1,
    parameter int HOLD_TICKS = 6,
    parameter int MAX_Y      = 100,
    parameter int MAX_FALL   = 15
) (
    input  logic              clk,
    input  logic              reset,
    dino_jump_ctrl_if.slave   bus
);
    localparam int HC_W = $clog2(HOLD_TICKS + 1);
    localparam int S_W  = Y_W + 1;

    typedef logic signed [S_W-1:0] sum_t;

    localparam sum_t Y_LIM    = sum_t'(MAX_Y);
    localparam sum_t FALL_LIM = sum_t'(-MAX_FALL);
    localparam sum_t G_NORM   = sum_t'(GRAVITY);
    localparam sum_t G_FAST   = sum_t'(2 * GRAVITY);
    localparam sum_t ZERO     = sum_t'(0);

    dino_state_e     state_q, state_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [V_W-1:0]  vel_q, vel_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            req_q, req_d;
    logic            start_q, start_d;
    logic            land_q, land_d;
    logic            duck_q, duck_d;
    logic            press;
    logic            airborne_w;

    sum_t y_ext, v_ext, g_ext, y_sum, v_new, v_fall;

    button_edge u_jump_edge (
        .clk        (clk),
        .reset      (reset),
        .level_in   (bus.jump_btn),
        .rise_pulse (press)
    );

    assign airborne_w = (state_q != GROUNDED);

    // Velocity is stored as raw two's complement; all sums run one bit wider than y so nothing wraps.
    always_comb begin
        y_ext  = $signed({1'b0, y_q});
        v_ext  = sum_t'(sext(32'(vel_q), V_W));
        g_ext  = (bus.duck_btn && airborne_w) ? G_FAST : G_NORM;
        y_sum  = y_ext + v_ext;
        v_new  = v_ext - g_ext;
        v_fall = (v_new < FALL_LIM) ? FALL_LIM : v_new;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GROUNDED;
            y_q     <= '0;
            vel_q   <= '0;
            hold_q  <= '0;
            req_q   <= 1'b0;
            start_q <= 1'b0;
            land_q  <= 1'b0;
            duck_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
            start_q <= start_d;
            land_q  <= land_d;
            duck_q  <= duck_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        hold_d  = hold_q;
        req_d   = req_q;
        start_d = 1'b0;
        land_d  = 1'b0;
        duck_d  = duck_q;

        if (bus.freeze) begin
            req_d = 1'b0;
        end else begin
            duck_d = bus.duck_btn && (state_q == GROUNDED);
            if (press && (state_q == GROUNDED)) begin
                req_d = 1'b1;
            end
            if (bus.tick_en) begin
                case (state_q)
                    GROUNDED: begin
                        if (req_q) begin
                            y_d     = Y_W'(JUMP_V);
                            vel_d   = V_W'(JUMP_V - GRAVITY);
                            hold_d  = '0;
                            req_d   = 1'b0;
                            start_d = 1'b1;
                            state_d = RISING;
                        end
                    end
                    RISING: begin
                        if (y_sum > Y_LIM) begin
                            y_d     = Y_W'(MAX_Y);
                            vel_d   = '0;
                            state_d = FALLING;
                        end else begin
                            y_d = y_sum[Y_W-1:0];
                            if (bus.jump_btn && (hold_q < HC_W'(HOLD_TICKS))) begin
                                hold_d = hold_q + HC_W'(1);
                            end else begin
                                vel_d = v_new[V_W-1:0];
                                if (v_new <= ZERO) begin
                                    state_d = FALLING;
                                end
                            end
                        end
                    end
                    FALLING: begin
                        if (y_sum <= ZERO) begin
                            y_d     = '0;
                            vel_d   = '0;
                            land_d  = 1'b1;
                            state_d = GROUNDED;
                        end else begin
                            y_d   = y_sum[Y_W-1:0];
                            vel_d = v_fall[V_W-1:0];
                        end
                    end
                    default: begin
                        y_d     = '0;
                        vel_d   = '0;
                        state_d = GROUNDED;
                    end
                endcase
            end
        end
    end

    assign bus.dino_y     = y_q;
    assign bus.airborne   = airborne_w;
    assign bus.ducking    = duck_q;
    assign bus.jump_start = start_q;
    assign bus.landed     = land_q;
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: cycle model feeds an expectation queue, plus fixed trajectory tables.
module tb_dino_jump_ctrl;

    logic clk = 1'b0;
    logic reset;

    dino_jump_ctrl_if #(.Y_W(7)) dif ();

    dino_jump_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        int air;
        int duck;
        int st;
        int ld;
    } exp_t;

    exp_t sb[$];
    int   ys[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam int ST_GND = 0;
    localparam int ST_UP  = 1;
    localparam int ST_DN  = 2;

    int m_y, m_v, m_st, m_h, m_req, m_bq, m_duck, m_start, m_land;

    int tap_up[12]   = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78};
    int tap_down[13] = '{78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
    int held_up[10]  = '{12, 23, 34, 45, 56, 67, 78, 89, 99, 100};
    int duck_down[10] = '{78, 76, 72, 66, 58, 48, 36, 22, 7, 0};

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit tk, input bit fz, input bit jb, input bit db);
        int  ny, nv, nst, nh, nreq, nduck, s, g, vn;
        bit  press;
        if (rst) begin
            m_y = 0; m_v = 0; m_st = ST_GND; m_h = 0; m_req = 0;
            m_bq = 0; m_duck = 0; m_start = 0; m_land = 0;
        end else begin
            press = jb && (m_bq == 0);
            ny = m_y; nv = m_v; nst = m_st; nh = m_h; nreq = m_req; nduck = m_duck;
            m_start = 0;
            m_land  = 0;
            if (fz) begin
                nreq = 0;
            end else begin
                nduck = (db && m_st == ST_GND) ? 1 : 0;
                if (press && m_st == ST_GND) nreq = 1;
                if (tk) begin
                    g = (db && m_st != ST_GND) ? 2 : 1;
                    s = m_y + m_v;
                    if (m_st == ST_GND) begin
                        if (m_req != 0) begin
                            ny = 12; nv = 11; nh = 0; nreq = 0; nst = ST_UP; m_start = 1;
                        end
                    end else if (m_st == ST_UP) begin
                        if (s > 100) begin
                            ny = 100; nv = 0; nst = ST_DN;
                        end else begin
                            ny = s;
                            if (jb && m_h < 6) nh = m_h + 1;
                            else begin
                                nv = m_v - g;
                                if (nv <= 0) nst = ST_DN;
                            end
                        end
                    end else begin
                        if (s <= 0) begin
                            ny = 0; nv = 0; nst = ST_GND; m_land = 1;
                        end else begin
                            ny = s;
                            vn = m_v - g;
                            nv = (vn < -15) ? -15 : vn;
                        end
                    end
                end
            end
            m_y = ny; m_v = nv; m_st = nst; m_h = nh; m_req = nreq; m_duck = nduck;
            m_bq = jb;
        end
    endtask

    // One clock: drive inputs, queue the model's expectation, compare after the edge.
    task automatic step(input bit rst, input bit tk, input bit fz, input bit jb, input bit db);
        exp_t e;
        reset        = rst;
        dif.tick_en  = tk;
        dif.freeze   = fz;
        dif.jump_btn = jb;
        dif.duck_btn = db;
        model_step(rst, tk, fz, jb, db);
        e.y = m_y; e.air = (m_st != ST_GND) ? 1 : 0; e.duck = m_duck; e.st = m_start; e.ld = m_land;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("dino_y", int'(dif.dino_y), e.y);
        check_eq("airborne", int'(dif.airborne), e.air);
        check_eq("ducking", int'(dif.ducking), e.duck);
        check_eq("jump_start", int'(dif.jump_start), e.st);
        check_eq("landed", int'(dif.landed), e.ld);
    endtask

    task automatic tick(input bit jb, input bit db, output int y_o, output int ld_o, output int st_o);
        step(1'b0, 1'b1, 1'b0, jb, db);
        y_o  = int'(dif.dino_y);
        ld_o = int'(dif.landed);
        st_o = int'(dif.jump_start);
        step(1'b0, 1'b0, 1'b0, jb, db);
    endtask

    task automatic run_to_land(input bit jb, input bit db, input int limit, output int n);
        int y, ld, st;
        bit done;
        done = 1'b0;
        n = 0;
        ys.delete();
        while (!done && n < limit) begin
            tick(jb, db, y, ld, st);
            ys.push_back(y);
            n++;
            if (ld != 0) done = 1'b1;
        end
        check_eq("landed_within_limit", int'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  y, ld, st, n;
        bit  jb_r, db_r, fz_r, tk_r;

        reset = 1'b1;
        dif.tick_en = 1'b0; dif.freeze = 1'b0; dif.jump_btn = 1'b0; dif.duck_btn = 1'b0;
        @(posedge clk); #1;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_y", int'(dif.dino_y), 0);
        check_eq("rst_airborne", int'(dif.airborne), 0);

        // Tap then climb to the apex
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, y, ld, st);
            check_eq("tap_rise_y", y, tap_up[i]);
            if (i == 0) check_eq("tap_jump_start", st, 1);
        end
        check_eq("tap_apex_airborne", int'(dif.airborne), 1);
        run_to_land(1'b0, 1'b0, 40, n);
        check_eq("tap_fall_ticks", n, 13);
        for (int i = 0; i < ys.size() && i < 13; i++) check_eq("tap_fall_y", ys[i], tap_down[i]);
        check_eq("tap_grounded", int'(dif.airborne), 0);

        // Held jump: hold window, then ceiling clamp
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, y, ld, st);
            check_eq("held_rise_y", y, held_up[i]);
        end
        run_to_land(1'b1, 1'b0, 60, n);
        check_eq("held_fall_ticks", n, 15);
        if (ys.size() >= 2) begin
            check_eq("clamp_hold_y", ys[0], 100);
            check_eq("clamp_next_y", ys[1], 99);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, y, ld, st);
            check_eq("held_no_relaunch", st, 0);
        end
        check_eq("held_still_grounded", int'(dif.airborne), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, y, ld, st);
        check_eq("repress_start", st, 1);
        check_eq("repress_y", y, 12);
        run_to_land(1'b0, 1'b0, 60, n);

        // Fast fall from the apex with duck held
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, y, ld, st);
        check_eq("duck_apex_y", y, 78);
        run_to_land(1'b0, 1'b1, 40, n);
        check_eq("duck_fall_ticks", n, 10);
        for (int i = 0; i < ys.size() && i < 10; i++) check_eq("duck_fall_y", ys[i], duck_down[i]);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("grounded_ducking", int'(dif.ducking), 1);
        check_eq("grounded_duck_y", int'(dif.dino_y), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Freeze mid-air at y=50
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, y, ld, st);
        check_eq("pre_freeze_y", y, 50);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, i[1], 1'b0);
            step(1'b0, 1'b0, 1'b1, i[1], 1'b0);
        end
        check_eq("frozen_y", int'(dif.dino_y), 50);
        check_eq("frozen_airborne", int'(dif.airborne), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, y, ld, st);
        check_eq("resume_y", y, 57);
        run_to_land(1'b0, 1'b0, 40, n);

        // Presses swallowed by freeze while grounded
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, y, ld, st);
        check_eq("frozen_press_ignored", st, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, y, ld, st);
        check_eq("freeze_clears_req", st, 0);
        check_eq("freeze_clears_air", int'(dif.airborne), 0);

        // Reset mid-air
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, y, ld, st);
        check_eq("pre_reset_y", y, 42);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("midair_reset_y", int'(dif.dino_y), 0);
        check_eq("midair_reset_air", int'(dif.airborne), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("midair_reset_nolanded", int'(dif.landed), 0);
        tick(1'b0, 1'b0, y, ld, st);
        check_eq("midair_reset_nostart", st, 0);

        // Random stretch against the model
        jb_r = 1'b0; db_r = 1'b0; fz_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)  jb_r = ~jb_r;
            if ($urandom_range(0, 15) == 0) db_r = ~db_r;
            if ($urandom_range(0, 40) == 0) fz_r = ~fz_r;
            tk_r = ($urandom_range(0, 2) == 0);
            step(1'b0, tk_r, fz_r, jb_r, db_r);
            check_eq("pulse_exclusive", int'(dif.jump_start & dif.landed), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
